// File: rtl/data_memory_ctrl_if.sv
// data_memory_ctrl_if: MEM-stage load/store request and response bus
interface data_memory_ctrl_if;
  logic        MemRead_MEM;
  logic        MemWrite_MEM;
  logic        Load_Byte_control;
  logic        Store_Byte_control;
  logic [31:0] Addr_MEM;
  logic [31:0] Write_data_MEM;
  logic [31:0] Read_data_MEM;
  logic        Stall_MEM;
  logic        Done_MEM;
  logic        Err_MEM;
  modport master (
    output MemRead_MEM, MemWrite_MEM, Load_Byte_control, Store_Byte_control, Addr_MEM, Write_data_MEM,
    input  Read_data_MEM, Stall_MEM, Done_MEM, Err_MEM
  );
  modport slave (
    input  MemRead_MEM, MemWrite_MEM, Load_Byte_control, Store_Byte_control, Addr_MEM, Write_data_MEM,
    output Read_data_MEM, Stall_MEM, Done_MEM, Err_MEM
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: word-wide data array serving lw/sw/lb/sb with wait states and pipeline stall
module data_memory_ctrl #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input logic             Clk,
  input logic             Rst_n,
  data_memory_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t          state;
  logic [3:0]      cnt;
  logic [AW-1:0]   idx;
  logic [1:0]      lane;
  logic [31:0]     wdata;
  logic            wr;
  logic            byte_op;
  logic [31:0]     mem [DEPTH];
  logic            bsel;
  logic            legal;
  logic            illegal;
  logic            commit;
  logic [31:0]     word;
  logic [7:0]      byte_val;
  logic            unused_addr;
  always_comb begin
    bsel        = bus.MemRead_MEM ? bus.Load_Byte_control : bus.Store_Byte_control;
    legal       = (bus.MemRead_MEM ^ bus.MemWrite_MEM) && (bsel || bus.Addr_MEM[1:0] == 2'b00);
    illegal     = (bus.MemRead_MEM | bus.MemWrite_MEM) & ~legal;
    commit      = state == ACCESS && cnt == 4'd0;
    word        = mem[idx];
    // big-endian lanes: lane 0 is the most significant byte
    byte_val    = 8'(word >> {~lane, 3'b000});
    bus.Stall_MEM = state == ACCESS || (state == IDLE && legal);
    unused_addr = ^bus.Addr_MEM[31:AW+2];
  end
  always_ff @(posedge Clk) begin
    if (Rst_n && commit && wr) begin
      if (byte_op) mem[idx][{~lane, 3'b000} +: 8] <= wdata[7:0];
      else mem[idx] <= wdata;
    end
  end
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state             <= IDLE;
      cnt               <= 4'd0;
      bus.Read_data_MEM <= 32'd0;
      bus.Done_MEM      <= 1'b0;
      bus.Err_MEM       <= 1'b0;
    end else begin
      bus.Done_MEM <= 1'b0;
      bus.Err_MEM  <= 1'b0;
      case (state)
        IDLE: begin
          if (legal) begin
            idx     <= bus.Addr_MEM[AW+1:2];
            lane    <= bus.Addr_MEM[1:0];
            wdata   <= bus.Write_data_MEM;
            wr      <= bus.MemWrite_MEM;
            byte_op <= bsel;
            cnt     <= 4'(WAIT_CYCLES);
            state   <= ACCESS;
          end else bus.Err_MEM <= illegal;
        end
        ACCESS: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else begin
            if (!wr) bus.Read_data_MEM <= byte_op ? {24'd0, byte_val} : word;
            bus.Done_MEM <= 1'b1;
            state        <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: table-driven scoreboard bench for two wait-state configurations
module tb_data_memory_ctrl;
  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;
  data_memory_ctrl_if bus0();
  data_memory_ctrl_if bus1();
  data_memory_ctrl #(.DEPTH(256), .WAIT_CYCLES(2)) dut0 (.Clk(Clk), .Rst_n(Rst_n), .bus(bus0));
  data_memory_ctrl #(.DEPTH(256), .WAIT_CYCLES(0)) dut1 (.Clk(Clk), .Rst_n(Rst_n), .bus(bus1));
  assign bus1.MemRead_MEM        = bus0.MemRead_MEM;
  assign bus1.MemWrite_MEM       = bus0.MemWrite_MEM;
  assign bus1.Load_Byte_control  = bus0.Load_Byte_control;
  assign bus1.Store_Byte_control = bus0.Store_Byte_control;
  assign bus1.Addr_MEM           = bus0.Addr_MEM;
  assign bus1.Write_data_MEM     = bus0.Write_data_MEM;
  typedef enum int {LW, LB, SW, SB, BOTH} op_t;
  typedef struct {op_t op; logic [31:0] addr; logic [31:0] data; logic [31:0] rd; bit err;} vec_t;
  typedef struct {bit err; logic [31:0] rd;} exp_t;
  exp_t sbq[$];
  exp_t e;
  vec_t tv[20];
  int n_cmp = 0;
  int n_bad = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge Clk) begin
    if (Rst_n && (bus0.Done_MEM || bus0.Err_MEM)) begin
      chk("done_err_exclusive", 32'(bus0.Done_MEM & bus0.Err_MEM), 32'd0);
      if (sbq.size() == 0) chk("unexpected_completion", 32'(sbq.size()), 32'd1);
      else begin
        e = sbq.pop_front();
        chk("err_flag", 32'(bus0.Err_MEM), 32'(e.err));
        chk("read_data", bus0.Read_data_MEM, e.rd);
      end
    end
  end
  task automatic clear_inputs();
    bus0.MemRead_MEM = 0; bus0.MemWrite_MEM = 0;
    bus0.Load_Byte_control = 0; bus0.Store_Byte_control = 0;
    bus0.Addr_MEM = 0; bus0.Write_data_MEM = 0;
  endtask
  task automatic do_op(input vec_t v, input bit use1);
    int st0, st1;
    bit got0, got1;
    logic [31:0] rd1;
    bus0.MemRead_MEM        = v.op == LW || v.op == LB || v.op == BOTH;
    bus0.MemWrite_MEM       = v.op == SW || v.op == SB || v.op == BOTH;
    bus0.Load_Byte_control  = v.op == LB;
    bus0.Store_Byte_control = v.op == SB;
    bus0.Addr_MEM           = v.addr;
    bus0.Write_data_MEM     = v.data;
    sbq.push_back('{v.err, v.rd});
    #1 st0 = int'(bus0.Stall_MEM);
    st1 = int'(bus1.Stall_MEM);
    @(posedge Clk);
    #1 clear_inputs();
    got0 = 0; got1 = 0; rd1 = 'x;
    for (int i = 0; i < 40 && !got0; i++) begin
      @(negedge Clk);
      if (bus1.Done_MEM || bus1.Err_MEM) begin got1 = 1; rd1 = bus1.Read_data_MEM; end
      st0 += int'(bus0.Stall_MEM);
      st1 += int'(bus1.Stall_MEM);
      got0 = bus0.Done_MEM || bus0.Err_MEM;
    end
    chk("completion", 32'(got0), 32'd1);
    chk("stall_cycles", 32'(st0), v.err ? 32'd0 : 32'd4);
    if (use1) begin
      chk("w0_completion", 32'(got1), 32'd1);
      chk("w0_stall_cycles", 32'(st1), v.err ? 32'd0 : 32'd2);
      chk("w0_read_data", rd1, v.rd);
    end
    @(posedge Clk);
    @(negedge Clk);
  endtask
  initial begin
    tv[0]  = '{SW,   32'h10,  32'hDEADBEEF, 32'h00000000, 0};
    tv[1]  = '{LW,   32'h10,  32'h0,        32'hDEADBEEF, 0};
    tv[2]  = '{SW,   32'h20,  32'h11223344, 32'hDEADBEEF, 0};
    tv[3]  = '{SB,   32'h21,  32'hFFFFFFAA, 32'hDEADBEEF, 0};
    tv[4]  = '{LW,   32'h20,  32'h0,        32'h11AA3344, 0};
    tv[5]  = '{LB,   32'h20,  32'h0,        32'h00000011, 0};
    tv[6]  = '{LB,   32'h21,  32'h0,        32'h000000AA, 0};
    tv[7]  = '{LB,   32'h22,  32'h0,        32'h00000033, 0};
    tv[8]  = '{LB,   32'h23,  32'h0,        32'h00000044, 0};
    tv[9]  = '{LW,   32'h22,  32'h0,        32'h00000044, 1};
    tv[10] = '{BOTH, 32'h20,  32'h0,        32'h00000044, 1};
    tv[11] = '{LW,   32'h20,  32'h0,        32'h11AA3344, 0};
    tv[12] = '{SW,   32'h400, 32'h0000CAFE, 32'h11AA3344, 0};
    tv[13] = '{LW,   32'h0,   32'h0,        32'h0000CAFE, 0};
    tv[14] = '{SB,   32'h3,   32'h12345677, 32'h0000CAFE, 0};
    tv[15] = '{LB,   32'h401, 32'h0,        32'h00000000, 0};
    tv[16] = '{LW,   32'h0,   32'h0,        32'h0000CA77, 0};
    tv[17] = '{SW,   32'h30,  32'h0,        32'h0000CA77, 0};
    tv[18] = '{SW,   32'h31,  32'h1,        32'h0000CA77, 1};
    tv[19] = '{LB,   32'h402, 32'h0,        32'h000000CA, 0};
    clear_inputs();
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("reset_read_data", bus0.Read_data_MEM, 32'd0);
    chk("reset_done", 32'(bus0.Done_MEM), 32'd0);
    chk("reset_err", 32'(bus0.Err_MEM), 32'd0);
    chk("reset_stall", 32'(bus0.Stall_MEM), 32'd0);
    Rst_n = 1'b1;
    for (int i = 0; i < 20; i++) do_op(tv[i], 1'b1);
    bus0.MemWrite_MEM = 1; bus0.Addr_MEM = 32'h30; bus0.Write_data_MEM = 32'h55;
    @(posedge Clk);
    #1 clear_inputs();
    @(negedge Clk);
    @(negedge Clk);
    chk("abort_stall_before_reset", 32'(bus0.Stall_MEM), 32'd1);
    Rst_n = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    chk("abort_stall", 32'(bus0.Stall_MEM), 32'd0);
    chk("abort_done", 32'(bus0.Done_MEM), 32'd0);
    chk("abort_err", 32'(bus0.Err_MEM), 32'd0);
    chk("abort_read_data", bus0.Read_data_MEM, 32'd0);
    Rst_n = 1'b1;
    do_op('{LW, 32'h30, 32'h0, 32'h0, 0}, 1'b0);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
